// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter_n synchronizer/deglitch block.
package sync_filter_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned FILTER_LEN_MAX  = 255;

  // Stability counter width: $clog2(FILTER_LEN), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned filter_len);
    return (filter_len <= 2) ? 1 : $clog2(filter_len);
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: synchronizer chain, stability counter and event flops.
// rise_o/fall_o flops exist only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_bit
  import sync_filter_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o,
  output logic match_c_o
);

  localparam int unsigned            CNT_W   = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(FILTER_LEN - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  logic             smp;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             glitch_q, glitch_d;

  assign smp = sync_q[STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
    end
  end

  // A change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    glitch_d = 1'b0;
    if (smp == lvl_q) begin
      if (cnt_q != '0) begin
        cnt_d    = '0;
        glitch_d = 1'b1;
      end
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = smp;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      glitch_q <= glitch_d;
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

  assign sig_o     = lvl_q;
  assign glitch_o  = glitch_q;
  assign match_c_o = (smp == lvl_q);

endmodule

// File: rtl/sync_filter_n.sv
// Multi-bit CDC synchronizer with per-bit deglitch filter and event pulses.
// Define SYNC_FILTER_EDGE_EN to build the rise_o/fall_o registers.
module sync_filter_n
  import sync_filter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] sig_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] glitch_o,
  output logic             stable_o
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_n: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end

  if (FILTER_LEN < 1 || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filter
    $error("sync_filter_n: FILTER_LEN must be in 1..%0d", FILTER_LEN_MAX);
  end

  logic [WIDTH-1:0] match_c;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    sync_filter_bit #(
      .STAGES    (STAGES),
      .FILTER_LEN(FILTER_LEN)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sig_i    (sig_i[b]),
      .sig_o    (sig_o[b]),
      .rise_o   (rise_o[b]),
      .fall_o   (fall_o[b]),
      .glitch_o (glitch_o[b]),
      .match_c_o(match_c[b])
    );
  end

  // Stable when every synchronized sample already agrees with its output.
  assign stable_o = &match_c;

endmodule
